// File: rtl/bus_master_seq.sv
// bus_master_seq: single-outstanding register-bus initiator with masked writes,
// acknowledge timeout and a valid/ready response port.
`default_nettype none

module bus_master_seq #(
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 16
) (
  input  logic                  bus_clk,
  input  logic                  bus_reset_l,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [15:0]           cmd_data,
  input  logic [15:0]           cmd_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [15:0]           rsp_data,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_wr_data,
  output logic                  bus_we,
  output logic                  bus_re,
  input  logic [15:0]           bus_rd_data,
  input  logic                  bus_rd_ack,
  input  logic                  bus_wr_ack,
  output logic [7:0]            err_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Strobe-cycle index (0-based) of the last cycle before a timeout is declared.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  we_q, we_d;
  logic                  re_q, re_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [15:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [7:0]            errcnt_q, errcnt_d;
  logic                  ack;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^cmd_addr[1:0];
  assign ack = write_q ? bus_wr_ack : bus_rd_ack;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    we_d     = we_q;
    re_d     = re_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    errcnt_d = errcnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
          wdata_d = {cmd_mask, cmd_data};
          write_d = cmd_write;
          we_d    = cmd_write;
          re_d    = !cmd_write;
          cnt_d   = 8'd0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // The ack is tested before the timeout so an ack in the final strobe cycle wins.
        if (ack) begin
          we_d    = 1'b0;
          re_d    = 1'b0;
          rdata_d = write_q ? 16'h0000 : bus_rd_data;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          we_d    = 1'b0;
          re_d    = 1'b0;
          rdata_d = 16'h0000;
          err_d   = 1'b1;
          if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: begin
        we_d    = 1'b0;
        re_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge bus_clk or negedge bus_reset_l) begin
    if (!bus_reset_l) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      cnt_q    <= 8'd0;
      rdata_q  <= 16'h0000;
      err_q    <= 1'b0;
      errcnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      we_q     <= we_d;
      re_q     <= re_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_data    = rdata_q;
  assign rsp_err     = err_q;
  assign bus_addr    = addr_q;
  assign bus_wr_data = wdata_q;
  assign bus_we      = we_q;
  assign bus_re      = re_q;
  assign err_count   = errcnt_q;

endmodule

`default_nettype wire
